// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide sequencer.
//   mdu_op_e    : operation encoding seen on the op port
//   mdu_state_e : sequencer FSM state
//   op_is_mul   : multiply ops use shift-add; divide ops use restoring shift-subtract
//   op_takes_low: MUL and DIVU return the low accumulator half; MULHU and REMU return the high half
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_mul(mdu_op_e op);
    return (op == MDU_MUL) || (op == MDU_MULHU);
  endfunction

  function automatic logic op_takes_low(mdu_op_e op);
    return (op == MDU_MUL) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the pipeline (master) and the sequencer (slave).
//   start, op, a, b           : request, master -> slave
//   busy, done, result, stall : status and result, slave -> master
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             stall;

  modport master (output start, op, a, b, input busy, done, result, stall);
  modport slave  (input start, op, a, b, output busy, done, result, stall);
endinterface

// File: rtl/mdu_shift_datapath.sv
// Operand, accumulator and result registers plus the per-iteration arithmetic.
//   accept       : capture op/a/b and clear the accumulator
//   step         : perform one iteration
//   last         : the current step is the final one; load result from it
//   op_in, a_in, b_in : request fields, sampled on accept
//   result       : selected result, held between final steps
// The shift register walks its operand MSB-first: the multiplier for
// multiplies, the dividend for divides. For divides the accumulator is
// {remainder, quotient}.
module mdu_shift_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             step,
  input  logic             last,
  input  mdu_op_e          op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opa, opb, sh;
  mdu_op_e            op_q;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   res_nxt;

  always_comb begin
    // trial is one bit wider than the remainder: the shifted partial
    // remainder can reach 2*divisor-1.
    trial   = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
    ge      = trial >= {1'b0, opb};
    diff    = trial[WIDTH-1:0] - opb;
    acc_nxt = '0;
    if (op_is_mul(op_q)) begin
      acc_nxt = (acc << 1) + (sh[WIDTH-1] ? {{WIDTH{1'b0}}, opa} : '0);
    end else begin
      // divisor 0 makes ge always true: quotient all ones, remainder = dividend
      acc_nxt = {(ge ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end
    res_nxt = op_takes_low(op_q) ? acc_nxt[WIDTH-1:0] : acc_nxt[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      sh     <= '0;
      op_q   <= MDU_MUL;
      result <= '0;
    end else if (accept) begin
      acc  <= '0;
      opa  <= a_in;
      opb  <= b_in;
      sh   <= op_is_mul(op_in) ? b_in : a_in;
      op_q <= op_in;
    end else if (step) begin
      acc <= acc_nxt;
      sh  <= sh << 1;
      if (last) result <= res_nxt;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit: FSM, iteration counter and pipeline handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mdu_if (start/op/a/b in; busy/done/result/stall out)
//
// state | meaning
// IDLE  | waiting for start; result holds last value
// RUN   | one iteration per cycle, counter counts down to 0
// DONE  | single-cycle done pulse, result valid, pipeline released
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, step, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (accept)               cnt_q <= CNT_W'(WIDTH - 1);
    else if (step && cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  // Gated by rst so a start held during reset does not freeze the pipeline.
  assign bus.stall = ~rst & (((state_q == ST_IDLE) & bus.start) | (state_q == ST_RUN));

  mdu_shift_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .step   (step),
    .last   (last),
    .op_in  (bus.op),
    .a_in   (bus.a),
    .b_in   (bus.b),
    .result (bus.result)
  );

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: scoreboard of expected results,
// one task per scenario.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb[$];

  mdu_if #(.WIDTH(32)) bus ();

  mdu_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(mdu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      MDU_MUL:   return p[31:0];
      MDU_MULHU: return p[63:32];
      MDU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives start for one cycle starting at a negedge (DUT must be in IDLE),
  // pushes the expected result, and returns #1 after the accept edge.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic stall_k);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    sb.push_back(model(op, a, b));
    #1 stall_k = bus.stall;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    bus.op = mdu_op_e'($urandom_range(0, 3));
  endtask

  // Waits (bounded) for done, counting busy and stall cycles; optionally
  // pulses start with garbage operands during busy cycle index inject_at.
  task automatic wait_done(input int inject_at, output int nbusy, output int nstall,
                           output bit seen);
    nbusy = 0; nstall = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy)  nbusy++;
      if (bus.stall) nstall++;
      if (i == inject_at) begin
        bus.start = 1'b1; bus.op = MDU_MUL; bus.a = $urandom; bus.b = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.op = MDU_MUL; bus.a = 32'd3; bus.b = 32'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b stall=%b result=%h required 0 0 0 0",
               bus.busy, bus.done, bus.stall, bus.result);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_mul();
    logic sk; int nb, ns; bit seen; logic [31:0] exp;
    issue(MDU_MUL, 32'd7, 32'd6, sk);
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || nb != 32) begin
      errors++;
      $display("FAIL mul_latency seen=%0d busy_cycles=%0d required 1 32", seen, nb);
    end
    checks++;
    if (bus.result !== exp || exp !== 32'h0000_002A) begin
      errors++;
      $display("FAIL mul_result got %h required %h", bus.result, 32'h0000_002A);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 32'h0000_002A) begin
      errors++;
      $display("FAIL mul_hold done=%b result=%h required 0 0000002a", bus.done, bus.result);
    end
  endtask

  task automatic test_mulhu();
    logic sk; int nb, ns; bit seen; logic [31:0] exp;
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sk);
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || bus.result !== exp) begin
      errors++;
      $display("FAIL mulhu_result got %h required %h", bus.result, exp);
    end
    @(posedge clk); #1;
    issue(MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sk);
    checks++;
    if (bus.result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL result_hold_in_run got %h required fffffffe", bus.result);
    end
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || bus.result !== exp) begin
      errors++;
      $display("FAIL mul_ones_result got %h required %h", bus.result, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    logic sk; int nb, ns; bit seen; logic [31:0] exp;
    issue(MDU_DIVU, 32'd100, 32'd7, sk);
    checks++;
    if (sk !== 1'b1) begin
      errors++;
      $display("FAIL div_stall_at_accept got %b required 1", sk);
    end
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || bus.result !== exp || nb != 32 || ns != 32) begin
      errors++;
      $display("FAIL divu_result got %h busy=%0d stall=%0d required %h 32 32",
               bus.result, nb, ns, exp);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL div_stall_at_done got %b required 0", bus.stall);
    end
    @(posedge clk); #1;
    issue(MDU_REMU, 32'd100, 32'd7, sk);
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || bus.result !== exp) begin
      errors++;
      $display("FAIL remu_result got %h required %h", bus.result, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    logic sk; int nb, ns; bit seen; logic [31:0] exp;
    issue(MDU_DIVU, 32'h1234_5678, 32'd0, sk);
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || nb != 32 || bus.result !== exp) begin
      errors++;
      $display("FAIL divu_zero got %h busy=%0d required %h 32", bus.result, nb, exp);
    end
    @(posedge clk); #1;
    issue(MDU_REMU, 32'h1234_5678, 32'd0, sk);
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || nb != 32 || bus.result !== exp) begin
      errors++;
      $display("FAIL remu_zero got %h busy=%0d required %h 32", bus.result, nb, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic sk; int nb, ns; bit seen; logic [31:0] exp;
    issue(MDU_DIVU, 32'd1000, 32'd9, sk);
    wait_done(4, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || nb != 32 || bus.result !== exp) begin
      errors++;
      $display("FAIL start_in_run got %h busy=%0d required %h 32", bus.result, nb, exp);
    end
    bus.start = 1'b1; bus.op = MDU_MUL; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== exp) begin
      errors++;
      $display("FAIL start_in_done busy=%b result=%h required 0 %h", bus.busy, bus.result, exp);
    end
  endtask

  task automatic test_reset_abort();
    logic sk; int nb, ns; bit seen; int ndone; logic [31:0] exp;
    issue(MDU_DIVU, 32'hDEAD_BEEF, 32'd3, sk);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_front());
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort busy=%b stall=%b result=%h required 0 0 0",
               bus.busy, bus.stall, bus.result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL no_done_after_abort active_cycles=%0d required 0", ndone);
    end
    issue(MDU_MULHU, 32'h8000_0001, 32'h0000_0010, sk);
    wait_done(-1, nb, ns, seen);
    exp = sb.pop_front();
    checks++;
    if (!seen || nb != 32 || bus.result !== exp) begin
      errors++;
      $display("FAIL op_after_abort got %h busy=%0d required %h 32", bus.result, nb, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic sk; int nb, ns; bit seen; logic [31:0] exp, a, b; mdu_op_e op;
    for (int n = 0; n < 8; n++) begin
      op = mdu_op_e'(n % 4);
      a  = (n == 0) ? 32'd0 : $urandom;
      b  = (n == 1) ? 32'd1 : (n == 6) ? 32'hFFFF_FFFF : $urandom_range(1, 32'hFFFF);
      issue(op, a, b, sk);
      wait_done(-1, nb, ns, seen);
      exp = sb.pop_front();
      checks++;
      if (!seen || nb != 32 || bus.result !== exp) begin
        errors++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h got %h busy=%0d required %h 32",
                 n, op, a, b, bus.result, nb, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = MDU_MUL; bus.a = '0; bus.b = '0;
    test_reset();
    test_mul();
    test_mulhu();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
